unified_buffer_mp: RTL and testbench

UNIFIED_BUFFER_MP -- requirements
Module: unified_buffer_mp

---
 rtl/unified_buffer_mp.sv | 116 +++++++++++
 tb/tb_unified_buffer_mp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/unified_buffer_mp.sv
// unified_buffer_mp: row-wide scratchpad with a priority master port plus independent rd/wr ports.
// Optional macro UB_RAW_FWD_EN forwards a same-cycle, same-row wr_data to the rd port.
module unified_buffer_mp #(
  parameter int MATRIX_WIDTH = 14,
  parameter int TILE_WIDTH   = 4096,
  parameter int ADDR_WIDTH   = 24,
  parameter int READ_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      m_req,
  input  logic [ADDR_WIDTH-1:0]     m_addr,
  input  logic [MATRIX_WIDTH-1:0]   m_we,
  input  logic [MATRIX_WIDTH*8-1:0] m_wdata,
  output logic [MATRIX_WIDTH*8-1:0] m_rdata,
  output logic                      m_rvalid,
  input  logic                      rd_req,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_grant,
  output logic [MATRIX_WIDTH*8-1:0] rd_data,
  output logic                      rd_valid,
  input  logic                      wr_req,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [MATRIX_WIDTH*8-1:0] wr_data,
  output logic                      wr_grant,
  output logic                      addr_err,
  input  logic                      err_clr
);

  localparam int ROW_W = MATRIX_WIDTH * 8;
  localparam int IDX_W = (TILE_WIDTH > 1) ? $clog2(TILE_WIDTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(TILE_WIDTH);

  logic [ROW_W-1:0] mem [TILE_WIDTH];

  logic             m_acc, m_ok, rd_ok, wr_ok, err_set;
  logic [IDX_W-1:0] m_idx, rd_idx, wr_idx;
  logic [ROW_W-1:0] m_row, rd_row;

  logic [READ_LATENCY-1:0] rd_pv, m_pv;
  logic [ROW_W-1:0]        rd_pd [READ_LATENCY];
  logic [ROW_W-1:0]        m_pd  [READ_LATENCY];

  assign m_acc    = enable & m_req;
  assign rd_grant = enable & rd_req & ~m_req;
  assign wr_grant = enable & wr_req & ~m_req;

  assign m_ok  = {1'b0, m_addr}  < DEPTH;
  assign rd_ok = {1'b0, rd_addr} < DEPTH;
  assign wr_ok = {1'b0, wr_addr} < DEPTH;

  assign m_idx  = m_addr[IDX_W-1:0];
  assign rd_idx = rd_addr[IDX_W-1:0];
  assign wr_idx = wr_addr[IDX_W-1:0];

  assign err_set = (m_acc & ~m_ok) | (rd_grant & ~rd_ok) | (wr_grant & ~wr_ok);

  // Out-of-range rows read as zero; the array is read before the edge, giving read-before-write.
  always_comb begin
    m_row  = '0;
    rd_row = '0;
    if (m_ok)  m_row  = mem[m_idx];
    if (rd_ok) rd_row = mem[rd_idx];
`ifdef UB_RAW_FWD_EN
    if (rd_ok && wr_grant && wr_ok && (wr_addr == rd_addr)) rd_row = wr_data;
`endif
  end

  // Master and wr port are mutually exclusive because m_req masks wr_grant.
  always_ff @(posedge clk) begin
    if (m_acc && m_ok) begin
      for (int i = 0; i < MATRIX_WIDTH; i++) begin
        if (m_we[i]) mem[m_idx][i*8 +: 8] <= m_wdata[i*8 +: 8];
      end
    end else if (wr_grant && wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Data only advances behind a valid tag so the outputs hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pv <= '0;
      m_pv  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd_pd[i] <= '0;
        m_pd[i]  <= '0;
      end
    end else if (enable) begin
      rd_pv[0] <= rd_grant;
      m_pv[0]  <= m_acc;
      if (rd_grant) rd_pd[0] <= rd_row;
      if (m_acc)    m_pd[0]  <= m_row;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pv[i] <= rd_pv[i-1];
        m_pv[i]  <= m_pv[i-1];
        if (rd_pv[i-1]) rd_pd[i] <= rd_pd[i-1];
        if (m_pv[i-1])  m_pd[i]  <= m_pd[i-1];
      end
    end
  end

  assign rd_valid = rd_pv[READ_LATENCY-1];
  assign rd_data  = rd_pd[READ_LATENCY-1];
  assign m_rvalid = m_pv[READ_LATENCY-1];
  assign m_rdata  = m_pd[READ_LATENCY-1];

  // A new error wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          addr_err <= 1'b0;
    else if (err_set) addr_err <= 1'b1;
    else if (err_clr) addr_err <= 1'b0;
  end

endmodule

// File: tb/tb_unified_buffer_mp.sv
// tb_unified_buffer_mp: directed checks of unified_buffer_mp at READ_LATENCY 2, plus 1 and 4 instances.
// Expected same-row read data follows UB_RAW_FWD_EN the same way the design does.
module tb_unified_buffer_mp;
  localparam int MW = 14;
  localparam int TW = 16;
  localparam int AW = 8;
  localparam int RW = MW * 8;

  localparam logic [RW-1:0] ROW5   = 112'h0102030405060708090A0B0C0D0E;
  localparam logic [RW-1:0] OLD3   = 112'hF0E1D2C3B4A5968778695A4B3C2D;
  localparam logic [RW-1:0] NEW3   = 112'hF0E1D2C3B4A5968778695A4B3CAA;
  localparam logic [RW-1:0] ROW55  = {MW{8'h55}};
  localparam logic [RW-1:0] ROW88  = {MW{8'h88}};
  localparam logic [RW-1:0] ROW99  = {MW{8'h99}};
  localparam logic [RW-1:0] ZERO   = '0;
`ifdef UB_RAW_FWD_EN
  localparam logic [RW-1:0] SAME_ROW_EXP = ROW55;
`else
  localparam logic [RW-1:0] SAME_ROW_EXP = ZERO;
`endif

  logic          clk = 1'b0;
  logic          rst, enable, m_req, rd_req, wr_req, err_clr;
  logic [AW-1:0] m_addr, rd_addr, wr_addr;
  logic [MW-1:0] m_we;
  logic [RW-1:0] m_wdata, wr_data;

  logic [RW-1:0] m_rdata, rd_data, l1_m_rdata, l1_rd_data, l4_m_rdata, l4_rd_data;
  logic          m_rvalid, rd_valid, rd_grant, wr_grant, addr_err;
  logic          l1_m_rvalid, l1_rd_valid, l1_rd_grant, l1_wr_grant, l1_addr_err;
  logic          l4_m_rvalid, l4_rd_valid, l4_rd_grant, l4_wr_grant, l4_addr_err;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  unified_buffer_mp #(.MATRIX_WIDTH(MW), .TILE_WIDTH(TW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .m_req(m_req), .m_addr(m_addr), .m_we(m_we),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_grant(rd_grant), .rd_data(rd_data), .rd_valid(rd_valid), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_grant(wr_grant), .addr_err(addr_err), .err_clr(err_clr));

  unified_buffer_mp #(.MATRIX_WIDTH(MW), .TILE_WIDTH(TW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .enable(enable), .m_req(m_req), .m_addr(m_addr), .m_we(m_we),
    .m_wdata(m_wdata), .m_rdata(l1_m_rdata), .m_rvalid(l1_m_rvalid), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_grant(l1_rd_grant), .rd_data(l1_rd_data), .rd_valid(l1_rd_valid), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_grant(l1_wr_grant), .addr_err(l1_addr_err), .err_clr(err_clr));

  unified_buffer_mp #(.MATRIX_WIDTH(MW), .TILE_WIDTH(TW), .ADDR_WIDTH(AW), .READ_LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst), .enable(enable), .m_req(m_req), .m_addr(m_addr), .m_we(m_we),
    .m_wdata(m_wdata), .m_rdata(l4_m_rdata), .m_rvalid(l4_m_rvalid), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_grant(l4_rd_grant), .rd_data(l4_rd_data), .rd_valid(l4_rd_valid), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_grant(l4_wr_grant), .addr_err(l4_addr_err), .err_clr(err_clr));

  task automatic checkOutput(input string tag, input logic [RW-1:0] observed, input logic [RW-1:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; registered outputs are sampled there too.
  task automatic stepCycle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [RW-1:0] data);
    wr_req  = 1'b1;
    wr_addr = addr;
    wr_data = data;
    stepCycle();
    wr_req  = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [AW-1:0] addr, input logic [RW-1:0] expected);
    rd_req  = 1'b1;
    rd_addr = addr;
    stepCycle();
    rd_req  = 1'b0;
    stepCycle();
    checkOutput({tag, "_valid"}, RW'(rd_valid), RW'(1));
    checkOutput({tag, "_data"}, rd_data, expected);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; m_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0; err_clr = 1'b0;
    m_addr = '0; rd_addr = '0; wr_addr = '0; m_we = '0; m_wdata = '0; wr_data = '0;
    #3;
    checkOutput("rst_rd_valid", RW'(rd_valid), RW'(0));
    checkOutput("rst_rd_data", rd_data, ZERO);
    checkOutput("rst_m_rvalid", RW'(m_rvalid), RW'(0));
    checkOutput("rst_m_rdata", m_rdata, ZERO);
    checkOutput("rst_addr_err", RW'(addr_err), RW'(0));
    checkOutput("rst_l1_m", RW'({l1_m_rvalid, l1_addr_err}), RW'(0));
    checkOutput("rst_l4_m", RW'({l4_m_rvalid, l4_addr_err}), RW'(0));
    checkOutput("rst_l1_mdata", l1_m_rdata, ZERO);
    checkOutput("rst_l4_mdata", l4_m_rdata, ZERO);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    stepCycle();

    // Write row 5, then read it back on all three latencies.
    wr_req = 1'b1; wr_addr = 8'd5; wr_data = ROW5;
    #1;
    checkOutput("wr_grant", RW'({wr_grant, l1_wr_grant, l4_wr_grant}), RW'(3'b111));
    stepCycle();
    wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 8'd5;
    #1;
    checkOutput("rd_grant", RW'({rd_grant, l1_rd_grant, l4_rd_grant}), RW'(3'b111));
    stepCycle();
    rd_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checkOutput($sformatf("lat1_valid_k%0d", k), RW'(l1_rd_valid), RW'(k == 1));
      checkOutput($sformatf("lat2_valid_k%0d", k), RW'(rd_valid), RW'(k == 2));
      checkOutput($sformatf("lat4_valid_k%0d", k), RW'(l4_rd_valid), RW'(k == 4));
      stepCycle();
    end
    checkOutput("lat1_data", l1_rd_data, ROW5);
    checkOutput("lat2_data", rd_data, ROW5);
    checkOutput("lat4_data", l4_rd_data, ROW5);

    // Master byte write collides with an rd request; master wins and returns the old row.
    applyStimulus(8'd3, OLD3);
    m_req = 1'b1; m_addr = 8'd3; m_we = 14'h0001; m_wdata = {104'h0, 8'hAA};
    rd_req = 1'b1; rd_addr = 8'd3;
    #1;
    checkOutput("m_prio_rd_grant", RW'(rd_grant), RW'(0));
    stepCycle();
    m_req = 1'b0; m_we = '0; rd_req = 1'b0;
    checkOutput("m_rvalid_k1", RW'(m_rvalid), RW'(0));
    stepCycle();
    checkOutput("m_rvalid_k2", RW'(m_rvalid), RW'(1));
    checkOutput("m_rdata_old", m_rdata, OLD3);
    checkOutput("m_prio_no_rd", RW'(rd_valid), RW'(0));
    stepCycle();
    checkOutput("m_rvalid_single", RW'(m_rvalid), RW'(0));
    checkOutput("m_rdata_hold", m_rdata, OLD3);
    readCheck("m_byte_write", 8'd3, NEW3);

    // Same-row and different-row concurrent rd/wr.
    applyStimulus(8'd7, ZERO);
    wr_req = 1'b1; wr_addr = 8'd7; wr_data = ROW55;
    rd_req = 1'b1; rd_addr = 8'd7;
    stepCycle();
    wr_req = 1'b0; rd_req = 1'b0;
    stepCycle();
    checkOutput("same_row_valid", RW'(rd_valid), RW'(1));
    checkOutput("same_row_data", rd_data, SAME_ROW_EXP);
    readCheck("same_row_after", 8'd7, ROW55);
    wr_req = 1'b1; wr_addr = 8'd8; wr_data = ROW88;
    rd_req = 1'b1; rd_addr = 8'd5;
    stepCycle();
    wr_req = 1'b0; rd_req = 1'b0;
    stepCycle();
    checkOutput("diff_row_data", rd_data, ROW5);
    readCheck("diff_row_wr", 8'd8, ROW88);

    // Stall the pipeline for three cycles after accepting a read of row 9.
    applyStimulus(8'd9, ROW99);
    rd_req = 1'b1; rd_addr = 8'd9;
    stepCycle();
    rd_addr = 8'd5; enable = 1'b0;
    #1;
    checkOutput("stall_no_grant", RW'(rd_grant), RW'(0));
    for (int k = 2; k <= 4; k++) begin
      stepCycle();
      checkOutput($sformatf("stall_valid_k%0d", k), RW'(rd_valid), RW'(0));
    end
    checkOutput("stall_data_hold", rd_data, ROW88);
    rd_req = 1'b0; enable = 1'b1;
    stepCycle();
    checkOutput("stall_valid_k5", RW'(rd_valid), RW'(1));
    checkOutput("stall_data", rd_data, ROW99);
    stepCycle();
    checkOutput("stall_single", RW'(rd_valid), RW'(0));

    // Out-of-range accesses, sticky error and clear priority.
    rd_req = 1'b1; rd_addr = 8'(TW + 1);
    stepCycle();
    rd_req = 1'b0;
    checkOutput("oor_err_set", RW'(addr_err), RW'(1));
    stepCycle();
    checkOutput("oor_valid", RW'(rd_valid), RW'(1));
    checkOutput("oor_data", rd_data, ZERO);
    checkOutput("oor_err_sticky", RW'(addr_err), RW'(1));
    err_clr = 1'b1;
    stepCycle();
    err_clr = 1'b0;
    checkOutput("oor_err_clr", RW'(addr_err), RW'(0));
    rd_req = 1'b1; rd_addr = 8'(TW + 1); err_clr = 1'b1;
    stepCycle();
    rd_req = 1'b0; err_clr = 1'b0;
    checkOutput("set_beats_clr", RW'(addr_err), RW'(1));
    m_req = 1'b1; m_addr = 8'(TW); m_we = '1; m_wdata = ROW55;
    stepCycle();
    m_req = 1'b0; m_we = '0; err_clr = 1'b1;
    stepCycle();
    err_clr = 1'b0;
    checkOutput("m_oor_valid", RW'(m_rvalid), RW'(1));
    checkOutput("m_oor_data", m_rdata, ZERO);
    checkOutput("m_oor_err_clr", RW'(addr_err), RW'(0));
    applyStimulus(8'd0, ROW88);
    applyStimulus(8'(TW), ROW55);
    checkOutput("wr_oor_err", RW'(addr_err), RW'(1));
    readCheck("wr_oor_no_alias", 8'd0, ROW88);
    applyStimulus(8'(TW - 1), ROW99);
    readCheck("last_row", 8'(TW - 1), ROW99);

    // Reset one cycle after an accepted read discards it.
    rd_req = 1'b1; rd_addr = 8'd5;
    stepCycle();
    rd_req = 1'b0; rst = 1'b1;
    #1;
    checkOutput("rst_flight_valid", RW'(rd_valid), RW'(0));
    checkOutput("rst_flight_data", rd_data, ZERO);
    checkOutput("rst_flight_l4", l4_rd_data, ZERO);
    stepCycle();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      stepCycle();
      checkOutput($sformatf("rst_no_valid_%0d", k), RW'({rd_valid, l1_rd_valid, l4_rd_valid}), RW'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
